// File: rtl/forwarding_hazard_unit_n.sv
// EX-stage operand forwarding and hazard detection for the MIPS pipeline.
// Tracks one in-flight multi-cycle mult/div and stalls its dependents until the result is ready.
module forwarding_hazard_unit_n #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_LAT     = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 2)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC*REG_AW-1:0]      ex_src,
  input  logic [NUM_SRC-1:0]             ex_src_used,
  input  logic [NUM_STAGES*REG_AW-1:0]   stg_rd,
  input  logic [NUM_STAGES-1:0]          stg_reg_write,
  input  logic [NUM_STAGES-1:0]          stg_mem_read,
  input  logic                           md_start,
  input  logic [REG_AW-1:0]              md_rd,
  input  logic                           md_kill,
  output logic [NUM_SRC*SEL_W-1:0]       fwd_sel,
  output logic                           stall,
  output logic                           md_busy,
  output logic                           md_done
);

  localparam int unsigned CNT_W = $clog2(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 2);
  localparam logic [SEL_W-1:0] SEL_MD   = SEL_W'(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] md_rd_q, md_rd_d;

  logic [REG_AW-1:0] src_v;
  logic [SEL_W-1:0]  sel_v;
  logic              hit_v;
  logic              ld_v;
  logic              load_use;
  logic              md_dep;

  assign md_busy = (state_q == MD_BUSY);
  assign md_done = (state_q == MD_DONE);

  // Per-operand forwarding select; the first (youngest) matching stage wins.
  always_comb begin
    fwd_sel  = '0;
    src_v    = '0;
    sel_v    = '0;
    hit_v    = 1'b0;
    ld_v     = 1'b0;
    load_use = 1'b0;
    md_dep   = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_v = ex_src[i*REG_AW +: REG_AW];
      sel_v = '0;
      hit_v = 1'b0;
      ld_v  = 1'b0;
      if (ex_src_used[i] && (src_v != '0)) begin
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
          if (!hit_v && stg_reg_write[k] && (stg_rd[k*REG_AW +: REG_AW] == src_v)) begin
            hit_v = 1'b1;
            sel_v = SEL_W'(k + 1);
            ld_v  = stg_mem_read[k];
          end
        end
        if (!hit_v && md_done && (md_rd_q == src_v)) begin
          sel_v = SEL_MD;
        end
        if (ld_v) begin
          load_use = 1'b1;
        end
        if (md_busy && (md_rd_q == src_v)) begin
          md_dep = 1'b1;
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = sel_v;
    end
    stall = load_use | md_dep | (md_start & md_busy);
  end

  // Mult/div tracker; a start during BUSY is refused and only raises stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (md_start && !stall) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_INIT;
          md_rd_d = md_rd;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (md_kill) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      md_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit_n.sv
// Directed bench for forwarding_hazard_unit_n: default configuration plus a
// NUM_SRC=3 / NUM_STAGES=3 / MD_LAT=2 instance checked against a small model.
module tb_forwarding_hazard_unit_n;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  // Instance A: default parameters (SEL_W = 2)
  logic [9:0] src_a;
  logic [1:0] used_a;
  logic [9:0] rd_a;
  logic [1:0] we_a;
  logic [1:0] mr_a;
  logic       start_a;
  logic [4:0] mdrd_a;
  logic       kill_a;
  logic [3:0] fwd_a;
  logic       stall_a;
  logic       busy_a;
  logic       done_a;

  // Instance B: 3 sources, 3 stages, MD_LAT=2 (SEL_W = 3)
  logic [14:0] src_b;
  logic [2:0]  used_b;
  logic [14:0] rd_b;
  logic [2:0]  we_b;
  logic [2:0]  mr_b;
  logic        start_b;
  logic [4:0]  mdrd_b;
  logic        kill_b;
  logic [8:0]  fwd_b;
  logic        stall_b;
  logic        busy_b;
  logic        done_b;

  logic [8:0]  exp_sel_b;
  logic        exp_stall_b;

  forwarding_hazard_unit_n dut_a (
    .clk(clk), .reset(reset),
    .ex_src(src_a), .ex_src_used(used_a),
    .stg_rd(rd_a), .stg_reg_write(we_a), .stg_mem_read(mr_a),
    .md_start(start_a), .md_rd(mdrd_a), .md_kill(kill_a),
    .fwd_sel(fwd_a), .stall(stall_a), .md_busy(busy_a), .md_done(done_a)
  );

  forwarding_hazard_unit_n #(
    .NUM_SRC(3), .NUM_STAGES(3), .REG_AW(5), .MD_LAT(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .ex_src(src_b), .ex_src_used(used_b),
    .stg_rd(rd_b), .stg_reg_write(we_b), .stg_mem_read(mr_b),
    .md_start(start_b), .md_rd(mdrd_b), .md_kill(kill_b),
    .fwd_sel(fwd_b), .stall(stall_b), .md_busy(busy_b), .md_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [9:0] s, input logic [1:0] u, input logic [9:0] r,
                       input logic [1:0] w, input logic [1:0] m);
    src_a  = s;
    used_a = u;
    rd_a   = r;
    we_a   = w;
    mr_a   = m;
  endtask

  // Reference: scan oldest to youngest so the youngest match overwrites.
  function automatic void ref_b(input logic [14:0] s, input logic [2:0] u, input logic [14:0] r,
                                input logic [2:0] w, input logic [2:0] m, input logic mdd,
                                input logic mdb, input logic [4:0] mdr,
                                output logic [8:0] sel, output logic st);
    logic [4:0] sv;
    logic [2:0] one;
    logic       ld;
    sel = '0;
    st  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv  = s[i*5 +: 5];
      one = 3'd0;
      ld  = 1'b0;
      if (u[i] && sv != 5'd0) begin
        for (int k = 2; k >= 0; k--) begin
          if (w[k] && r[k*5 +: 5] == sv) begin
            one = 3'(k + 1);
            ld  = m[k];
          end
        end
        if (one == 3'd0 && mdd && mdr == sv) one = 3'd4;
        if (ld || (mdb && mdr == sv)) st = 1'b1;
      end
      sel[i*3 +: 3] = one;
    end
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    set_a(10'd0, 2'd0, 10'd0, 2'd0, 2'd0);
    start_a = 1'b0; mdrd_a = 5'd0; kill_a = 1'b0;
    src_b = '0; used_b = '0; rd_b = '0; we_b = '0; mr_b = '0;
    start_b = 1'b0; mdrd_b = 5'd0; kill_b = 1'b0;

    #12;
    check("reset_busy",  32'(busy_a),  32'd0);
    check("reset_done",  32'(done_a),  32'd0);
    check("reset_stall", 32'(stall_a), 32'd0);
    check("reset_fwd",   32'(fwd_a),   32'd0);
    reset = 1'b0;
    tick();

    // Forwarding and priority: src = {rt=9, rs=8}
    set_a({5'd9, 5'd8}, 2'b11, {5'd9, 5'd8}, 2'b11, 2'b00); #1;
    check("fwd_basic", 32'(fwd_a), 32'b1001);
    check("fwd_basic_stall", 32'(stall_a), 32'd0);
    set_a({5'd9, 5'd8}, 2'b11, {5'd8, 5'd8}, 2'b11, 2'b00); #1;
    check("prio_young", 32'(fwd_a), 32'b0001);
    set_a({5'd9, 5'd8}, 2'b11, {5'd8, 5'd0}, 2'b11, 2'b00); #1;
    check("prio_old", 32'(fwd_a), 32'b0010);
    set_a({5'd9, 5'd8}, 2'b11, {5'd3, 5'd0}, 2'b11, 2'b00); #1;
    check("rd_zero", 32'(fwd_a), 32'd0);
    set_a({5'd9, 5'd0}, 2'b11, {5'd0, 5'd0}, 2'b11, 2'b11); #1;
    check("src_zero_fwd", 32'(fwd_a), 32'd0);
    check("src_zero_stall", 32'(stall_a), 32'd0);
    set_a({5'd9, 5'd8}, 2'b11, {5'd9, 5'd8}, 2'b00, 2'b00); #1;
    check("we_zero", 32'(fwd_a), 32'd0);

    // Load-use
    set_a({5'd9, 5'd8}, 2'b11, {5'd0, 5'd8}, 2'b01, 2'b01); #1;
    check("lu_stall", 32'(stall_a), 32'd1);
    check("lu_fwd", 32'(fwd_a), 32'b0001);
    set_a({5'd9, 5'd8}, 2'b10, {5'd0, 5'd8}, 2'b01, 2'b01); #1;
    check("lu_unused", 32'(stall_a), 32'd0);
    check("lu_unused_fwd", 32'(fwd_a), 32'd0);
    set_a({5'd9, 5'd8}, 2'b11, {5'd8, 5'd8}, 2'b11, 2'b10); #1;
    check("lu_old_masked", 32'(stall_a), 32'd0);
    set_a({5'd9, 5'd8}, 2'b11, {5'd8, 5'd3}, 2'b11, 2'b10); #1;
    check("lu_old_only", 32'(stall_a), 32'd1);
    check("lu_old_only_fwd", 32'(fwd_a), 32'b0010);
    set_a({5'd9, 5'd8}, 2'b11, {5'd8, 5'd8}, 2'b11, 2'b01); #1;
    check("lu_young_not_masked", 32'(stall_a), 32'd1);

    // Mult/div: start at cycle T with md_rd=12
    set_a(10'd0, 2'b00, 10'd0, 2'b00, 2'b00);
    start_a = 1'b1; mdrd_a = 5'd12; #1;
    check("md_start_stall", 32'(stall_a), 32'd0);
    tick();
    start_a = 1'b0;
    set_a({5'd0, 5'd12}, 2'b01, 10'd0, 2'b00, 2'b00); #1;
    check("md_t1_busy", 32'(busy_a), 32'd1);
    check("md_t1_dep_stall", 32'(stall_a), 32'd1);
    check("md_t1_fwd", 32'(fwd_a), 32'd0);
    tick();
    set_a(10'd0, 2'b00, 10'd0, 2'b00, 2'b00);
    start_a = 1'b1; mdrd_a = 5'd5; #1;
    check("md_t2_struct_stall", 32'(stall_a), 32'd1);
    check("md_t2_busy", 32'(busy_a), 32'd1);
    tick();
    start_a = 1'b0; #1;
    check("md_t3_busy", 32'(busy_a), 32'd1);
    check("md_t3_done", 32'(done_a), 32'd0);
    tick();
    set_a({5'd0, 5'd12}, 2'b01, 10'd0, 2'b00, 2'b00);
    start_a = 1'b1; mdrd_a = 5'd7; #1;
    check("md_t4_done", 32'(done_a), 32'd1);
    check("md_t4_busy", 32'(busy_a), 32'd0);
    check("md_t4_fwd", 32'(fwd_a), 32'b0011);
    check("md_t4_stall", 32'(stall_a), 32'd0);
    tick();
    start_a = 1'b0;
    set_a(10'd0, 2'b00, 10'd0, 2'b00, 2'b00); #1;
    check("md_b2b_busy", 32'(busy_a), 32'd1);
    check("md_b2b_done", 32'(done_a), 32'd0);
    tick();
    kill_a = 1'b1; #1;
    tick();
    kill_a = 1'b0; #1;
    check("kill_busy", 32'(busy_a), 32'd0);
    check("kill_done", 32'(done_a), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("kill_no_done", 32'(done_a), 32'd0);
    end

    // Kill beats start in the same cycle
    start_a = 1'b1; kill_a = 1'b1; mdrd_a = 5'd12; #1;
    tick();
    start_a = 1'b0; kill_a = 1'b0; #1;
    check("kill_prio_busy", 32'(busy_a), 32'd0);

    // Async reset mid-BUSY
    start_a = 1'b1; mdrd_a = 5'd12; #1;
    tick();
    start_a = 1'b0; #1;
    check("rst_pre_busy", 32'(busy_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_busy", 32'(busy_a), 32'd0);
    check("rst_async_done", 32'(done_a), 32'd0);
    tick();
    #2 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_no_done", 32'(done_a), 32'd0);
    end

    // Randomized forwarding/stall on the 3x3 instance with idle mult/div
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        src_b[i*5 +: 5] = 5'($urandom_range(3, 0));
        rd_b[i*5 +: 5]  = 5'($urandom_range(3, 0));
      end
      used_b = 3'($urandom_range(7, 0));
      we_b   = 3'($urandom_range(7, 0));
      mr_b   = 3'($urandom_range(7, 0));
      #1;
      ref_b(src_b, used_b, rd_b, we_b, mr_b, 1'b0, 1'b0, 5'd0, exp_sel_b, exp_stall_b);
      check("sweep_fwd", 32'(fwd_b), 32'(exp_sel_b));
      check("sweep_stall", 32'(stall_b), 32'(exp_stall_b));
      tick();
    end

    // MD_LAT=2: done exactly two cycles after the start cycle
    src_b = '0; used_b = '0; rd_b = '0; we_b = '0; mr_b = '0;
    start_b = 1'b1; mdrd_b = 5'd6; #1;
    tick();
    start_b = 1'b0;
    src_b = {5'd2, 5'd6, 5'd6};
    used_b = 3'b011;
    rd_b = {5'd0, 5'd0, 5'd6};
    we_b = 3'b001; #1;
    check("sw_t1_busy", 32'(busy_b), 32'd1);
    check("sw_t1_done", 32'(done_b), 32'd0);
    ref_b(src_b, used_b, rd_b, we_b, mr_b, 1'b0, 1'b1, 5'd6, exp_sel_b, exp_stall_b);
    check("sw_t1_stall", 32'(stall_b), 32'(exp_stall_b));
    tick();
    rd_b = {5'd0, 5'd0, 5'd2};
    we_b = 3'b001; #1;
    check("sw_t2_done", 32'(done_b), 32'd1);
    check("sw_t2_busy", 32'(busy_b), 32'd0);
    ref_b(src_b, used_b, rd_b, we_b, mr_b, 1'b1, 1'b0, 5'd6, exp_sel_b, exp_stall_b);
    check("sw_t2_fwd", 32'(fwd_b), 32'(exp_sel_b));
    check("sw_t2_fwd_const", 32'(fwd_b), 32'b000_100_100);
    tick();
    check("sw_t3_done", 32'(done_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
